// File: rtl/reg_piso_tx.sv
// Parallel-in serial-out transmitter with valid/ready load, pause and done pulse.
// Optional even-parity bit after the data word when REG_PISO_TX_PARITY_EN is defined.
module reg_piso_tx #(
    parameter int unsigned N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_valid,
    input  logic [N-1:0] din,
    input  logic         dir,
    input  logic         pause,
    output logic         load_ready,
    output logic         sout,
    output logic         shift_en,
    output logic         dir_out,
    output logic         busy,
    output logic         done
);

    localparam int unsigned CW = $clog2(N + 1);

`ifdef REG_PISO_TX_PARITY_EN
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PAR = 2'd2, DONE = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd3} state_t;
`endif

    state_t        state_q, state_d;
    logic [N-1:0]  hold_q, hold_d;
    logic          dir_q, dir_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          sout_q, sout_d;
    logic          shen_q, shen_d;
    logic          done_q, done_d;
    logic          busy_q, busy_d;

    logic [CW-1:0] cnt_inc;
    logic [CW-1:0] sel;
    logic          next_bit;

    // Bit count including the one strobed this cycle, and the next bit to present
    always_comb begin
        cnt_inc  = cnt_q + CW'(shen_q);
        sel      = dir_q ? cnt_inc : (CW'(N - 1) - cnt_inc);
        next_bit = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (sel == CW'(i)) next_bit = hold_q[i];
        end
    end

    // Next-state and registered-output decode
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        dir_d   = dir_q;
        cnt_d   = cnt_q;
        sout_d  = 1'b0;
        shen_d  = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (load_valid) begin
                    hold_d  = din;
                    dir_d   = dir;
                    cnt_d   = '0;
                    state_d = SHIFT;
                    shen_d  = 1'b1;
                    sout_d  = dir ? din[0] : din[N-1];
                end
            end
            SHIFT: begin
                cnt_d = cnt_inc;
                if (pause) begin
                    sout_d = sout_q;
                end else if (cnt_inc == CW'(N)) begin
`ifdef REG_PISO_TX_PARITY_EN
                    state_d = PAR;
                    shen_d  = 1'b1;
                    sout_d  = ^hold_q;
`else
                    state_d = DONE;
                    done_d  = 1'b1;
`endif
                end else begin
                    shen_d = 1'b1;
                    sout_d = next_bit;
                end
            end
`ifdef REG_PISO_TX_PARITY_EN
            PAR: begin
                if (shen_q) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else if (pause) begin
                    sout_d = sout_q;
                end else begin
                    shen_d = 1'b1;
                    sout_d = ^hold_q;
                end
            end
`endif
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            hold_q  <= '0;
            dir_q   <= 1'b0;
            cnt_q   <= '0;
            sout_q  <= 1'b0;
            shen_q  <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            dir_q   <= dir_d;
            cnt_q   <= cnt_d;
            sout_q  <= sout_d;
            shen_q  <= shen_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign load_ready = (state_q == IDLE) && !rst;
    assign sout       = sout_q;
    assign shift_en   = shen_q;
    assign dir_out    = dir_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_reg_piso_tx.sv
// Directed bench for reg_piso_tx (N=4); define REG_PISO_TX_PARITY_EN to check the parity build.
module tb_reg_piso_tx;

    localparam int unsigned N = 4;
`ifdef REG_PISO_TX_PARITY_EN
    localparam int NB = 5;
`else
    localparam int NB = 4;
`endif
    localparam int DONE_AT = NB + 1;

    logic         clk;
    logic         rst;
    logic         load_valid;
    logic [N-1:0] din;
    logic         dir;
    logic         pause;
    logic         load_ready;
    logic         sout;
    logic         shift_en;
    logic         dir_out;
    logic         busy;
    logic         done;

    reg_piso_tx #(.N(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .din        (din),
        .dir        (dir),
        .pause      (pause),
        .load_ready (load_ready),
        .sout       (sout),
        .shift_en   (shift_en),
        .dir_out    (dir_out),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int errors;

    logic [31:0] seq;
    int          nbits;
    int          done_cyc;
    int          ndone;
    logic        dir_bad;
    logic        hold_bad;
    logic        lr_after;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Accept one word, then record strobed bits, done timing and hold behaviour
    task automatic run_word(input logic [3:0] d, input logic dr, input logic [31:0] pmask,
                            input logic hold_lv);
        logic prev_sout;
        logic paused;
        seq      = '0;
        nbits    = 0;
        done_cyc = -1;
        ndone    = 0;
        dir_bad  = 1'b0;
        hold_bad = 1'b0;
        lr_after = 1'b0;
        check("accept_ready", 32'(load_ready), 32'd1);
        load_valid = 1'b1;
        din        = d;
        dir        = dr;
        step();
        dir = ~dr;
        if (hold_lv) din = 4'b0110;
        else         load_valid = 1'b0;
        prev_sout = 1'b0;
        paused    = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            if (shift_en) begin
                seq = {seq[30:0], sout};
                nbits++;
            end
            if (dir_out !== dr) dir_bad = 1'b1;
            if (paused && (shift_en !== 1'b0 || sout !== prev_sout)) hold_bad = 1'b1;
            if (done) begin
                ndone++;
                if (done_cyc < 0) done_cyc = c;
                load_valid = 1'b0;
            end
            if (done_cyc >= 0 && c == done_cyc + 1) begin
                lr_after = load_ready;
                break;
            end
            prev_sout = sout;
            paused    = pmask[c];
            pause     = pmask[c];
            step();
        end
        pause      = 1'b0;
        load_valid = 1'b0;
    endtask

    task automatic verify_word(input string t, input logic [31:0] exp_seq, input int exp_done);
        check({t, "_seq"},      seq,               exp_seq);
        check({t, "_nbits"},    32'(nbits),        32'(NB));
        check({t, "_done_cyc"}, 32'(done_cyc),     32'(exp_done));
        check({t, "_ndone"},    32'(ndone),        32'd1);
        check({t, "_dir_out"},  32'(dir_bad),      32'd0);
        check({t, "_pause"},    32'(hold_bad),     32'd0);
        check({t, "_ready"},    32'(lr_after),     32'd1);
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        rst        = 1'b1;
        load_valid = 1'b0;
        din        = '0;
        dir        = 1'b0;
        pause      = 1'b0;
        step();
        step();
        check("rst_ready_low", 32'(load_ready), 32'd0);
        rst = 1'b0;
        #1;
        check("rst_ready",    32'(load_ready), 32'd1);
        check("rst_busy",     32'(busy),       32'd0);
        check("rst_shift_en", 32'(shift_en),   32'd0);
        check("rst_sout",     32'(sout),       32'd0);
        check("rst_done",     32'(done),       32'd0);
        check("rst_dir_out",  32'(dir_out),    32'd0);

        // 1011 MSB first
        run_word(4'b1011, 1'b0, 32'h0, 1'b0);
`ifdef REG_PISO_TX_PARITY_EN
        verify_word("msb", 32'b10111, DONE_AT);
`else
        verify_word("msb", 32'b1011, DONE_AT);
`endif

        // 1011 LSB first
        run_word(4'b1011, 1'b1, 32'h0, 1'b0);
`ifdef REG_PISO_TX_PARITY_EN
        verify_word("lsb", 32'b11011, DONE_AT);
`else
        verify_word("lsb", 32'b1101, DONE_AT);
`endif

        // 0110 MSB first, even parity 0
        run_word(4'b0110, 1'b0, 32'h0, 1'b0);
`ifdef REG_PISO_TX_PARITY_EN
        verify_word("w0110", 32'b01100, DONE_AT);
`else
        verify_word("w0110", 32'b0110, DONE_AT);
`endif

        // pause during cycles 2-3 delays done by two cycles
        run_word(4'b1011, 1'b0, 32'h0000_000C, 1'b0);
`ifdef REG_PISO_TX_PARITY_EN
        verify_word("pause", 32'b10111, DONE_AT + 2);
`else
        verify_word("pause", 32'b1011, DONE_AT + 2);
`endif

        // load_valid held with a second word during shifting is ignored
        run_word(4'b1011, 1'b0, 32'h0, 1'b1);
`ifdef REG_PISO_TX_PARITY_EN
        verify_word("ignore", 32'b10111, DONE_AT);
`else
        verify_word("ignore", 32'b1011, DONE_AT);
`endif
        step();
        check("ignore_idle_busy", 32'(busy), 32'd0);

        // reset mid-word discards it with no done pulse
        load_valid = 1'b1;
        din        = 4'b1011;
        dir        = 1'b1;
        step();
        load_valid = 1'b0;
        step();
        check("mid_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check("mrst_sout",     32'(sout),       32'd0);
        check("mrst_shift_en", 32'(shift_en),   32'd0);
        check("mrst_done",     32'(done),       32'd0);
        check("mrst_busy",     32'(busy),       32'd0);
        check("mrst_dir_out",  32'(dir_out),    32'd0);
        check("mrst_ready",    32'(load_ready), 32'd1);
        ndone = 0;
        step();
        check("mrst_ready_next", 32'(load_ready), 32'd1);
        for (int c = 0; c < 6; c++) begin
            if (done) ndone++;
            step();
        end
        check("mrst_no_done", 32'(ndone), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
